// File: rtl/wrsw_traffic_gen_chk.sv
// Multi-channel Ethernet-style frame generator and checker.
// Each channel emits header + incrementing payload frames and checks received frames of the same shape.
//
// state     | meaning
// ----------+------------------------------------------------
// GEN_IDLE  | waiting for enable and an unfinished run
// GEN_HDR   | sending the 8 header words (MACs, ethertype, seq)
// GEN_PAY   | sending payload words seq+k
// GEN_DONE  | run of nframes complete, hold until enable drops
module wrsw_traffic_gen_chk #(
  parameter int unsigned g_num_channels = 6,
  parameter int unsigned g_len_width    = 11,
  parameter int unsigned g_cnt_width    = 32,
  parameter logic [47:0] g_dst_mac      = 48'h0050CAFEBABE,
  parameter logic [47:0] g_src_mac      = 48'h010203040506,
  parameter logic [15:0] g_ethertype    = 16'h88F7
) (
  input  logic                                  clk_sys_i,
  input  logic                                  rst_i,
  input  logic [g_num_channels-1:0]             ctrl_enable_i,
  input  logic [15:0]                           ctrl_nframes_i,
  input  logic [g_len_width-1:0]                ctrl_min_len_i,
  input  logic [g_len_width-1:0]                ctrl_max_len_i,
  input  logic                                  ctrl_clear_i,
  output logic [g_num_channels*16-1:0]          src_data_o,
  output logic [g_num_channels-1:0]             src_valid_o,
  output logic [g_num_channels-1:0]             src_last_o,
  input  logic [g_num_channels-1:0]             src_ready_i,
  input  logic [g_num_channels*16-1:0]          snk_data_i,
  input  logic [g_num_channels-1:0]             snk_valid_i,
  input  logic [g_num_channels-1:0]             snk_last_i,
  output logic [g_num_channels-1:0]             snk_ready_o,
  output logic [g_num_channels*g_cnt_width-1:0] stat_tx_frames_o,
  output logic [g_num_channels*g_cnt_width-1:0] stat_rx_ok_o,
  output logic [g_num_channels*g_cnt_width-1:0] stat_rx_err_o,
  output logic [g_num_channels-1:0]             gen_done_o,
  output logic [g_num_channels-1:0]             chk_err_o
);

  localparam int LW = g_len_width;
  localparam int CW = g_cnt_width;
  localparam logic [LW-1:0] LEN_ONE = LW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {GEN_IDLE, GEN_HDR, GEN_PAY, GEN_DONE} gen_state_e;

  function automatic logic [15:0] hdr_word(input logic [2:0] idx, input logic [15:0] seq);
    logic [15:0] w;
    case (idx)
      3'd0:    w = g_dst_mac[47:32];
      3'd1:    w = g_dst_mac[31:16];
      3'd2:    w = g_dst_mac[15:0];
      3'd3:    w = g_src_mac[47:32];
      3'd4:    w = g_src_mac[31:16];
      3'd5:    w = g_src_mac[15:0];
      3'd6:    w = g_ethertype;
      default: w = seq;
    endcase
    return w;
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CNT_ONE;
  endfunction

  for (genvar c = 0; c < g_num_channels; c++) begin : g_ch
    // generator
    gen_state_e    state_q, state_d;
    logic [2:0]    hidx_q, hidx_d;
    logic [LW-1:0] pidx_q, pidx_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] prev_len_q, prev_len_d;
    logic          first_q, first_d;
    logic [15:0]   seq_q, seq_d;
    logic [15:0]   sent_q, sent_d;
    logic [CW-1:0] tx_q, tx_d;
    logic          valid, last, frame_end, run_full;
    logic [15:0]   data;
    logic [LW-1:0] next_len;

    // min>max falls into the wrap branch every time, so every frame uses min
    assign next_len = (first_q || (prev_len_q >= ctrl_max_len_i)) ? ctrl_min_len_i
                                                                   : prev_len_q + LEN_ONE;
    assign run_full = (ctrl_nframes_i != 16'd0) && (sent_q >= ctrl_nframes_i);

    always_comb begin
      state_d    = state_q;
      hidx_d     = hidx_q;
      pidx_d     = pidx_q;
      len_d      = len_q;
      prev_len_d = prev_len_q;
      first_d    = first_q;
      seq_d      = seq_q;
      sent_d     = sent_q;
      tx_d       = tx_q;
      valid      = 1'b0;
      last       = 1'b0;
      data       = 16'h0000;
      frame_end  = 1'b0;
      unique case (state_q)
        GEN_IDLE: begin
          if (run_full) begin
            state_d = GEN_DONE;
          end else if (ctrl_enable_i[c]) begin
            state_d    = GEN_HDR;
            hidx_d     = 3'd0;
            pidx_d     = '0;
            len_d      = next_len;
            prev_len_d = next_len;
            first_d    = 1'b0;
          end
        end
        GEN_HDR: begin
          valid = 1'b1;
          data  = hdr_word(hidx_q, seq_q);
          last  = (hidx_q == 3'd7) && (len_q == '0);
          if (src_ready_i[c]) begin
            if (last)                frame_end = 1'b1;
            else if (hidx_q == 3'd7) state_d   = GEN_PAY;
            else                     hidx_d    = hidx_q + 3'd1;
          end
        end
        GEN_PAY: begin
          valid = 1'b1;
          data  = seq_q + 16'(pidx_q);
          last  = (pidx_q == len_q - LEN_ONE);
          if (src_ready_i[c]) begin
            if (last) frame_end = 1'b1;
            else      pidx_d    = pidx_q + LEN_ONE;
          end
        end
        GEN_DONE: begin
          if (!ctrl_enable_i[c]) begin
            state_d = GEN_IDLE;
            sent_d  = 16'd0;
            first_d = 1'b1;
          end
        end
        default: state_d = GEN_IDLE;
      endcase
      if (frame_end) begin
        seq_d   = seq_q + 16'd1;
        sent_d  = sent_q + 16'd1;
        state_d = ((ctrl_nframes_i != 16'd0) && (sent_d == ctrl_nframes_i)) ? GEN_DONE : GEN_IDLE;
        tx_d    = sat_inc(tx_q);
      end
      if (ctrl_clear_i) begin
        tx_d    = '0;
        first_d = 1'b1;
      end
    end

    always_ff @(posedge clk_sys_i) begin
      if (rst_i) begin
        state_q    <= GEN_IDLE;
        hidx_q     <= 3'd0;
        pidx_q     <= '0;
        len_q      <= '0;
        prev_len_q <= '0;
        first_q    <= 1'b1;
        seq_q      <= 16'd0;
        sent_q     <= 16'd0;
        tx_q       <= '0;
      end else begin
        state_q    <= state_d;
        hidx_q     <= hidx_d;
        pidx_q     <= pidx_d;
        len_q      <= len_d;
        prev_len_q <= prev_len_d;
        first_q    <= first_d;
        seq_q      <= seq_d;
        sent_q     <= sent_d;
        tx_q       <= tx_d;
      end
    end

    assign src_data_o[c*16 +: 16]       = data;
    assign src_valid_o[c]               = valid;
    assign src_last_o[c]                = last;
    assign gen_done_o[c]                = (state_q == GEN_DONE);
    assign stat_tx_frames_o[c*CW +: CW] = tx_q;

    // checker
    logic [3:0]    ridx_q, ridx_d;
    logic          ferr_q, ferr_d;
    logic          synced_q, synced_d;
    logic [15:0]   exp_seq_q, exp_seq_d;
    logic [15:0]   exp_pay_q, exp_pay_d;
    logic [CW-1:0] ok_q, ok_d;
    logic [CW-1:0] err_q, err_d;
    logic          pulse_q, pulse_d;
    logic          ready_q;
    logic          beat, beat_err;
    logic [15:0]   rx_data;

    assign rx_data = snk_data_i[c*16 +: 16];
    assign beat    = snk_valid_i[c] && ready_q;

    always_comb begin
      ridx_d    = ridx_q;
      ferr_d    = ferr_q;
      synced_d  = synced_q;
      exp_seq_d = exp_seq_q;
      exp_pay_d = exp_pay_q;
      ok_d      = ok_q;
      err_d     = err_q;
      pulse_d   = 1'b0;
      beat_err  = 1'b0;
      if (beat) begin
        if (ridx_q < 4'd7) begin
          beat_err = (rx_data != hdr_word(ridx_q[2:0], 16'h0000)) || snk_last_i[c];
        end else if (ridx_q == 4'd7) begin
          // expected seq follows the received one, so a gap costs exactly one error
          beat_err  = synced_q && (rx_data != exp_seq_q);
          exp_seq_d = rx_data + 16'd1;
          exp_pay_d = rx_data;
          synced_d  = 1'b1;
        end else begin
          beat_err  = (rx_data != exp_pay_q);
          exp_pay_d = exp_pay_q + 16'd1;
        end
        if (snk_last_i[c]) begin
          ridx_d = 4'd0;
          ferr_d = 1'b0;
          if (ferr_q || beat_err) begin
            err_d   = sat_inc(err_q);
            pulse_d = 1'b1;
          end else begin
            ok_d = sat_inc(ok_q);
          end
        end else begin
          ferr_d = ferr_q || beat_err;
          if (ridx_q != 4'd8) ridx_d = ridx_q + 4'd1;
        end
      end
      if (ctrl_clear_i) begin
        ok_d     = '0;
        err_d    = '0;
        synced_d = 1'b0;
      end
    end

    always_ff @(posedge clk_sys_i) begin
      if (rst_i) begin
        ridx_q    <= 4'd0;
        ferr_q    <= 1'b0;
        synced_q  <= 1'b0;
        exp_seq_q <= 16'd0;
        exp_pay_q <= 16'd0;
        ok_q      <= '0;
        err_q     <= '0;
        pulse_q   <= 1'b0;
        ready_q   <= 1'b0;
      end else begin
        ridx_q    <= ridx_d;
        ferr_q    <= ferr_d;
        synced_q  <= synced_d;
        exp_seq_q <= exp_seq_d;
        exp_pay_q <= exp_pay_d;
        ok_q      <= ok_d;
        err_q     <= err_d;
        pulse_q   <= pulse_d;
        ready_q   <= 1'b1;
      end
    end

    assign snk_ready_o[c]            = ready_q;
    assign chk_err_o[c]              = pulse_q;
    assign stat_rx_ok_o[c*CW +: CW]  = ok_q;
    assign stat_rx_err_o[c*CW +: CW] = err_q;
  end

endmodule
